// File: rtl/apb_pkg.sv
// Shared APB types and constants for the completer register bank.
// Holds FSM states, default widths, ID value and wait-state bounds.
package apb_pkg;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    localparam int APB_DATA_W = 8;
    localparam int APB_ADDR_W = 9;

    localparam logic [7:0] ID_VALUE_DEF = 8'h5A;

    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle between requester and completer.
// Clock and reset are kept as plain ports on the modules.
interface apb_if
    import apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic              PREADY;
    logic [DATA_W-1:0] PRDATA;
    logic              PSLVERR;

    modport master (
        output PSEL,
        output PENABLE,
        output PWRITE,
        output PADDR,
        output PWDATA,
        input  PREADY,
        input  PRDATA,
        input  PSLVERR
    );

    modport slave (
        input  PSEL,
        input  PENABLE,
        input  PWRITE,
        input  PADDR,
        input  PWDATA,
        output PREADY,
        output PRDATA,
        output PSLVERR
    );

endinterface

// File: rtl/apb_regbank.sv
// Register array behind the APB completer: entry 0 is a fixed ID,
// the rest are read/write with synchronous clear.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                NUM_REGS = 16,
    parameter int                DATA_W   = APB_DATA_W,
    parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(ID_VALUE_DEF),
    localparam int               IDX_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [DATA_W-1:0] rdata
);

    // Index 0 has no storage; it is the hardwired ID.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    always_ff @(posedge clk) begin
        for (int i = 1; i < NUM_REGS; i++) begin
            if (rst) begin
                regs[i] <= '0;
            end else if (we && widx == IDX_W'(i)) begin
                regs[i] <= wdata;
            end
        end
    end

    always_comb begin
        rdata = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (ridx == IDX_W'(i)) begin
                rdata = regs[i];
            end
        end
    end

endmodule

// File: rtl/apb_completer_regbank.sv
// APB completer: setup/access FSM with fixed wait states, error
// decode for out-of-range and ID writes, and a register bank.
module apb_completer_regbank
    import apb_pkg::*;
#(
    parameter int                DATA_W      = APB_DATA_W,
    parameter int                ADDR_W      = APB_ADDR_W,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_STATES = 2,
    parameter logic [DATA_W-1:0] ID_VALUE    = DATA_W'(ID_VALUE_DEF)
) (
    input  logic PCLK,
    input  logic PRESET,
    apb_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REGS);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic              ld;
    logic              ready;
    logic              we;
    logic [IDX_W-1:0]  idx_in;
    logic              range_err;
    logic              err_in;
    logic [DATA_W-1:0] rdata;

    // The top address bit is the slave select and takes no part here.
    assign idx_in    = bus.PADDR[IDX_W-1:0];
    assign range_err = |bus.PADDR[ADDR_W-2:IDX_W];
    assign err_in    = range_err || (bus.PWRITE && idx_in == '0);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (ld) begin
                idx_q   <= idx_in;
                write_q <= bus.PWRITE;
                wdata_q <= bus.PWDATA;
                err_q   <= err_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld      = 1'b0;
        ready   = 1'b0;
        we      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // PSEL with PENABLE already high is not a setup phase.
                if (bus.PSEL && !bus.PENABLE) begin
                    ld      = 1'b1;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.PSEL || !bus.PENABLE) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ready   = 1'b1;
                    we      = write_q && !err_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    apb_regbank #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .ID_VALUE (ID_VALUE)
    ) u_regbank (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we),
        .widx  (idx_q),
        .wdata (wdata_q),
        .ridx  (idx_q),
        .rdata (rdata)
    );

    assign bus.PREADY  = ready;
    assign bus.PRDATA  = (ready && !write_q && !err_q) ? rdata : '0;
    assign bus.PSLVERR = ready && err_q;

endmodule

// File: tb/tb_apb_completer_regbank.sv
// Directed bench for the APB completer: two instances, with two and
// with zero wait states, driven from a single linear sequence.
module tb_apb_completer_regbank;

    logic PCLK;
    logic PRESET;

    int checks = 0;
    int errors = 0;

    apb_if #(.ADDR_W(9), .DATA_W(8)) bus ();
    apb_if #(.ADDR_W(9), .DATA_W(8)) bus0 ();

    apb_completer_regbank #(
        .DATA_W      (8),
        .ADDR_W      (9),
        .NUM_REGS    (16),
        .WAIT_STATES (2),
        .ID_VALUE    (8'h5A)
    ) u_dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    apb_completer_regbank #(
        .DATA_W      (8),
        .ADDR_W      (9),
        .NUM_REGS    (16),
        .WAIT_STATES (0),
        .ID_VALUE    (8'h5A)
    ) u_dut0 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus0)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(negedge PCLK);
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
    endtask

    // One transfer on the two-wait instance; rdy_cyc is the access cycle
    // (1-based) where PREADY rose, 0 if it never did within the budget.
    task automatic xfer(input logic wr, input logic [8:0] a,
                        input logic [7:0] d, input int abort_after,
                        output int rdy_cyc, output logic [7:0] rd,
                        output logic err);
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = a;
        bus.PWRITE  = wr;
        bus.PWDATA  = d;
        rdy_cyc = 0;
        rd      = '0;
        err     = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge PCLK);
            if (abort_after != 0 && k > abort_after) begin
                bus.PSEL    = 1'b0;
                bus.PENABLE = 1'b0;
            end else begin
                bus.PENABLE = 1'b1;
            end
            bus.PADDR  = ~a;
            bus.PWDATA = ~d;
            #1;
            if (bus.PREADY) begin
                rdy_cyc = k;
                rd      = bus.PRDATA;
                err     = bus.PSLVERR;
                break;
            end
        end
    endtask

    int         cyc;
    logic [7:0] rd;
    logic       err;

    initial begin
        bus.PSEL     = 1'b0;
        bus.PENABLE  = 1'b0;
        bus.PWRITE   = 1'b0;
        bus.PADDR    = '0;
        bus.PWDATA   = '0;
        bus0.PSEL    = 1'b0;
        bus0.PENABLE = 1'b0;
        bus0.PWRITE  = 1'b0;
        bus0.PADDR   = '0;
        bus0.PWDATA  = '0;
        PRESET       = 1'b1;

        // Reset held two cycles with the bus pretending to be mid-access.
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b1;
        bus.PADDR   = 9'h003;
        @(negedge PCLK);
        #1;
        chk("rst_pready", bus.PREADY, 1'b0);
        chk("rst_prdata", bus.PRDATA, 8'h00);
        chk("rst_pslverr", bus.PSLVERR, 1'b0);
        PRESET = 1'b0;
        idle();

        xfer(1'b0, 9'h003, 8'h00, 0, cyc, rd, err);
        chk("rst_read3_cyc", cyc, 3);
        chk("rst_read3_data", rd, 8'h00);

        // Write then back-to-back read.
        xfer(1'b1, 9'h003, 8'hA5, 0, cyc, rd, err);
        chk("wr3_cyc", cyc, 3);
        chk("wr3_err", err, 1'b0);
        xfer(1'b0, 9'h003, 8'h00, 0, cyc, rd, err);
        chk("rd3_cyc", cyc, 3);
        chk("rd3_data", rd, 8'hA5);
        chk("rd3_err", err, 1'b0);
        xfer(1'b0, 9'h103, 8'h00, 0, cyc, rd, err);
        chk("rd3_selbit_data", rd, 8'hA5);
        chk("rd3_selbit_err", err, 1'b0);

        // ID register.
        xfer(1'b0, 9'h000, 8'h00, 0, cyc, rd, err);
        chk("id_rd_data", rd, 8'h5A);
        chk("id_rd_err", err, 1'b0);
        xfer(1'b1, 9'h000, 8'h11, 0, cyc, rd, err);
        chk("id_wr_cyc", cyc, 3);
        chk("id_wr_err", err, 1'b1);
        xfer(1'b0, 9'h000, 8'h00, 0, cyc, rd, err);
        chk("id_rd2_data", rd, 8'h5A);

        // Out of range read.
        xfer(1'b0, 9'h020, 8'h00, 0, cyc, rd, err);
        chk("oor_cyc", cyc, 3);
        chk("oor_err", err, 1'b1);
        chk("oor_data", rd, 8'h00);
        xfer(1'b1, 9'h023, 8'hEE, 0, cyc, rd, err);
        chk("oor_wr_err", err, 1'b1);
        xfer(1'b0, 9'h003, 8'h00, 0, cyc, rd, err);
        chk("oor_wr_alias", rd, 8'hA5);

        // Aborted write.
        xfer(1'b1, 9'h005, 8'h77, 1, cyc, rd, err);
        chk("abort_cyc", cyc, 0);
        idle();
        xfer(1'b0, 9'h005, 8'h00, 0, cyc, rd, err);
        chk("abort_rd5", rd, 8'h00);

        // Reset during the second access cycle of a write.
        idle();
        @(negedge PCLK);
        bus.PSEL    = 1'b1;
        bus.PENABLE = 1'b0;
        bus.PADDR   = 9'h007;
        bus.PWRITE  = 1'b1;
        bus.PWDATA  = 8'h3C;
        @(negedge PCLK);
        bus.PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        #1;
        chk("mid_rst_pready", bus.PREADY, 1'b0);
        chk("mid_rst_prdata", bus.PRDATA, 8'h00);
        chk("mid_rst_pslverr", bus.PSLVERR, 1'b0);
        PRESET = 1'b0;
        // PSEL and PENABLE both high in IDLE must be ignored.
        @(negedge PCLK);
        #1;
        chk("viol_pready", bus.PREADY, 1'b0);
        idle();
        xfer(1'b0, 9'h007, 8'h00, 0, cyc, rd, err);
        chk("mid_rst_rd7", rd, 8'h00);
        xfer(1'b0, 9'h003, 8'h00, 0, cyc, rd, err);
        chk("mid_rst_rd3", rd, 8'h00);
        idle();

        // Zero-wait instance: write then back-to-back read.
        @(negedge PCLK);
        bus0.PSEL    = 1'b1;
        bus0.PENABLE = 1'b0;
        bus0.PADDR   = 9'h002;
        bus0.PWRITE  = 1'b1;
        bus0.PWDATA  = 8'h42;
        #1;
        chk("ws0_setup_pready", bus0.PREADY, 1'b0);
        @(negedge PCLK);
        bus0.PENABLE = 1'b1;
        bus0.PWDATA  = 8'hFF;
        #1;
        chk("ws0_wr_pready", bus0.PREADY, 1'b1);
        chk("ws0_wr_err", bus0.PSLVERR, 1'b0);
        @(negedge PCLK);
        bus0.PENABLE = 1'b0;
        bus0.PWRITE  = 1'b0;
        #1;
        chk("ws0_rd_setup", bus0.PREADY, 1'b0);
        @(negedge PCLK);
        bus0.PENABLE = 1'b1;
        #1;
        chk("ws0_rd_pready", bus0.PREADY, 1'b1);
        chk("ws0_rd_data", bus0.PRDATA, 8'h42);
        @(negedge PCLK);
        bus0.PSEL    = 1'b0;
        bus0.PENABLE = 1'b0;
        @(negedge PCLK);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_completer_regbank.md
# apb_completer_regbank

APB completer (slave) with an internal register bank, programmable wait states and error signalling. It is the responding end of the APB transfers issued by the team's APB master. It decodes the setup/access phases, inserts a fixed number of wait states via PREADY, commits writes and returns read data. It flags illegal accesses on PSLVERR.

## Interface
- DATA_W, 8: PWDATA/PRDATA width.
- ADDR_W, 9: PADDR width; bit ADDR_W-1 is the slave-select bit and is ignored by this block.
- NUM_REGS, 16: register count, power of two, ≥2.
- WAIT_STATES, 2: wait cycles inserted in every access phase, 0..15.
- ID_VALUE, 8'h5A: read-only contents of register 0.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  completer selected.
- PENABLE  in  1  access phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PREADY  out  1  transfer completes this cycle.
- PRDATA  out  DATA_W  read data, valid only while PREADY=1 and PWRITE=0.
- PSLVERR  out  1  error response, valid only while PREADY=1.

## Operation
- Index = PADDR[$clog2(NUM_REGS)-1:0].
- Address is in range when PADDR[ADDR_W-2:$clog2(NUM_REGS)] == 0.
- Register 0 is read-only and returns ID_VALUE. Registers 1..NUM_REGS-1 are read/write and reset to 0.
- Error condition (err) is set for either case:
  - address out of range;
  - write to register 0.
- An erroring transfer:
  - completes normally with the full wait-state count;
  - asserts PSLVERR=1 together with PREADY;
  - writes nothing;
  - returns PRDATA=0.
- FSM states:
  - IDLE:
    - On PSEL=1 && PENABLE=0 (setup phase), latch PADDR, PWRITE, PWDATA and err; load cnt=WAIT_STATES; go to ACCESS.
  - ACCESS:
    - If PSEL=0 or PENABLE=0, abort: return to IDLE with no write and no PREADY.
    - Else if cnt≠0: decrement cnt and stay in ACCESS.
    - Else (cnt==0): transfer completes. Commit the write if latched write && !err. Go to IDLE.
- Back-to-back transfers: the next setup phase is sampled in IDLE on the cycle after completion. There are no idle cycles beyond those required by APB.
- Register data, address and direction are taken from the values latched in setup. Changes on PADDR/PWDATA during ACCESS are ignored.

## Timing
- Reset (PRESET=1 at an edge):
  - state=IDLE, cnt=0;
  - registers 1..N-1 = 0;
  - PREADY=0, PRDATA=0, PSLVERR=0 from the following cycle.
- Reset during ACCESS aborts the transfer. No write is committed.
- PREADY = (state==ACCESS) && (cnt==0) && PSEL && PENABLE. It is combinational from registered state.
- PRDATA = PREADY && !write && !err ? reg[index] : 0.
- PSLVERR = PREADY && err.
- Latency from setup cycle T0:
  - access cycles run T1..T1+WAIT_STATES;
  - PREADY is high exactly in cycle T1+WAIT_STATES;
  - with WAIT_STATES=0, PREADY is high in T1.
- A write is visible to a read whose setup phase is in the cycle after completion.
- Simultaneous PSEL=1 && PENABLE=1 observed in IDLE (protocol violation) is ignored. The block stays IDLE.

## Structure
- Package apb_pkg holds:
  - state enum (IDLE, ACCESS);
  - default ID_VALUE constant;
  - WAIT_STATES upper-bound constant;
  - the shared APB width constants (DATA_W=8, ADDR_W=9).
- Sub-module apb_regbank:
  - register array with write-enable, index and wdata;
  - combinational read;
  - register 0 hardwired to ID_VALUE.
- FSM, wait counter and error decode live in the top module.

## Test plan
- Reset: hold PRESET=1 for 2 cycles, then read index 3. Expect PREADY=0/PRDATA=0/PSLVERR=0 during reset and PRDATA=0x00 on the read.
- Write then read, WAIT_STATES=2: write 0xA5 to PADDR=0x003.
  - Expect PREADY low in T1 and T2, high in T3, PSLVERR=0.
  - Back-to-back read of 0x003 returns PRDATA=0xA5.
- ID register: read 0x000 returns 0x5A. Write 0x11 to 0x000 gives PSLVERR=1 with PREADY. A subsequent read still returns 0x5A.
- Out of range, NUM_REGS=16: read PADDR=0x020. Expect PSLVERR=1 and PRDATA=0x00 with PREADY in T3.
- Abort: write 0x77 to 0x005 and drop PSEL after T1. Expect no PREADY. A read of 0x005 returns 0x00.
- Reset mid-transfer: assert PRESET in T2 of a write of 0x3C to 0x007. Expect outputs 0 the next cycle and register 7 reading 0x00.
- WAIT_STATES=0 variant: write 0x42 to 0x002. Expect PREADY in T1; read-back returns 0x42.
